tinyml_crop_scheduler: RTL and testbench
========================================

TINYML_CROP_SCHEDULER -- requirements
Module: tinyml_crop_scheduler

Interface
REQ-001 Parameter N_WIN SHALL exist: default 4, legal range 1..4, number of crop-window slots.
REQ-002 Ports SHALL be as follows; one clock, reset asynchronous and active-low:
- in_pclk  in  1  pixel clock; all logic on rising edge.
- in_arstn  in  1  asynchronous active-low reset.
- in_enable  in  1  scheduler run enable.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_idx  in  2  target slot.
- cfg_en  in  1  slot enable bit.
- cfg_x_start, cfg_x_win, cfg_y_start, cfg_y_win  in  11 each  window geometry.
- in_x, in_y  in  11 each  pixel coordinates from the camera pipeline.
- in_valid  in  1  pixel qualifier.
- in_ack  in  1  downstream has consumed the completed crop.
- out_x_start, out_x_win, out_y_start, out_y_win  out  11 each  geometry for the crop datapath.
- out_win_idx  out  2  slot currently scheduled.
- out_crop_en  out  1  crop datapath enable for the current frame.
- out_done  out  1  one-cycle pulse at end of crop window.
- out_busy  out  1  high in any state other than IDLE.
- out_cfg_err  out  1  one-cycle pulse on a rejected write.

Function
REQ-003 Each slot SHALL hold an enable bit and four 11-bit geometry fields, written on cfg_we.
REQ-004 A write SHALL be rejected, slot unchanged, out_cfg_err pulsed next cycle, if any of these hold: cfg_idx >= N_WIN; x_win == 0; y_win == 0; 12-bit x_start+x_win > 2048; 12-bit y_start+y_win > 2048.
REQ-005 The FSM SHALL have states IDLE, ARM, WAIT_SOF, ACTIVE, WAIT_ACK.
REQ-006 IDLE->ARM SHALL occur when in_enable=1 and at least one slot is enabled.
REQ-007 ARM SHALL last exactly one cycle and do the following:
- Select the next enabled slot round-robin, searching from last_idx+1 cyclically, with last_idx itself checked last.
- Load its geometry into the out_* geometry registers, set out_win_idx and last_idx.
- Go to WAIT_SOF.
- If no slot is enabled, go to IDLE instead.
REQ-008 SOF SHALL be defined as in_valid && in_x==0 && in_y==0; an SOF sampled during ARM SHALL be ignored.
REQ-009 WAIT_SOF->ACTIVE SHALL occur on SOF, and out_crop_en SHALL be 1 from the cycle after SOF until the cycle after EOF.
REQ-010 EOF SHALL be defined as in_valid && in_x==out_x_start+out_x_win-1 && in_y==out_y_start+out_y_win-1, compared at 12 bits.
REQ-011 ACTIVE->WAIT_ACK SHALL occur on EOF, with out_done=1 for exactly the following cycle.
REQ-012 WAIT_ACK on in_ack=1 SHALL go to ARM if in_enable=1, otherwise to IDLE.
REQ-013 If ACTIVE sees an SOF before EOF (short frame), it SHALL abandon the window, go to WAIT_ACK and pulse out_done.
REQ-014 in_enable=0 SHALL force ARM/WAIT_SOF to IDLE next cycle; in ACTIVE the window SHALL complete first.
REQ-015 Geometry outputs SHALL stay constant outside ARM; writes to the scheduled slot take effect only at the next ARM.
REQ-016 If a config write and ARM occur in the same cycle, ARM SHALL use the pre-write slot contents.
REQ-017 out_busy SHALL equal (state != IDLE), registered.

Reset
REQ-018 Asynchronous in_arstn=0 SHALL clear the following immediately, including mid-frame:
- All slots: enable=0, geometry=0.
- State=IDLE, last_idx=N_WIN-1.
- All outputs to 0.
REQ-019 After deassertion, the block SHALL wait in IDLE for a new enable; any frame in progress SHALL be discarded.

Verification
REQ-020 Reset, then write slot0 = (x_start 100, x_win 240, y_start 0, y_win 540, en 1), set enable, run a 1920x1080 raster -> required response:
- out_crop_en rises the cycle after (0,0).
- out_done pulses once, the cycle after pixel (339,539).
- out_x_start=100.
REQ-021 Enable slots 0, 1 and 3, acking every frame -> out_win_idx sequence 0,1,3,0,1.
REQ-022 Write x_start=2000 with x_win=100 -> out_cfg_err pulses; slot contents unchanged.
REQ-023 Drop in_enable mid-ACTIVE -> window completes, out_done pulses; ack -> IDLE, out_busy=0.
REQ-024 Assert in_arstn low at pixel (500,300) of an active window -> all outputs 0 immediately; no out_done after release.
REQ-025 Send a 100-line frame against y_win=540 -> on the next SOF: out_done pulses, state goes to WAIT_ACK, out_crop_en=0.

Source files
------------

// File: rtl/tinyml_crop_scheduler.sv
// Crop-window scheduler: holds up to N_WIN crop windows, picks enabled slots
// round-robin once per frame and frames the crop datapath between SOF and the
// window's last pixel (EOF), then waits for the downstream acknowledge.
module tinyml_crop_scheduler #(
  parameter int unsigned N_WIN = 4
) (
  input  logic        in_pclk,
  input  logic        in_arstn,
  input  logic        in_enable,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic        cfg_en,
  input  logic [10:0] cfg_x_start,
  input  logic [10:0] cfg_x_win,
  input  logic [10:0] cfg_y_start,
  input  logic [10:0] cfg_y_win,
  input  logic [10:0] in_x,
  input  logic [10:0] in_y,
  input  logic        in_valid,
  input  logic        in_ack,
  output logic [10:0] out_x_start,
  output logic [10:0] out_x_win,
  output logic [10:0] out_y_start,
  output logic [10:0] out_y_win,
  output logic [1:0]  out_win_idx,
  output logic        out_crop_en,
  output logic        out_done,
  output logic        out_busy,
  output logic        out_cfg_err
);

  typedef enum logic [2:0] {StIdle, StArm, StWaitSof, StActive, StWaitAck} state_e;

  state_e state_q, state_d;

  logic [N_WIN-1:0] slot_en;
  logic [10:0]      slot_xs [N_WIN];
  logic [10:0]      slot_xw [N_WIN];
  logic [10:0]      slot_ys [N_WIN];
  logic [10:0]      slot_yw [N_WIN];

  logic [1:0]  last_idx_q;
  logic [10:0] x_start_q, x_win_q, y_start_q, y_win_q;
  logic [1:0]  win_idx_q;
  logic        crop_en_q, done_q, busy_q, cfg_err_q;

  logic [11:0] x_sum, y_sum, x_end, y_end;
  logic        cfg_ok, sof, eof, found, load;
  logic [1:0]  sel, cand;

  // Config write validation; sums are 12 bits so they cannot wrap.
  always_comb begin
    x_sum  = {1'b0, cfg_x_start} + {1'b0, cfg_x_win};
    y_sum  = {1'b0, cfg_y_start} + {1'b0, cfg_y_win};
    cfg_ok = (32'(cfg_idx) < N_WIN) && (cfg_x_win != 11'd0) && (cfg_y_win != 11'd0) &&
             (x_sum <= 12'd2048) && (y_sum <= 12'd2048);
  end

  // Slot table; only accepted writes land.
  always_ff @(posedge in_pclk or negedge in_arstn) begin
    if (!in_arstn) begin
      slot_en <= '0;
      for (int i = 0; i < int'(N_WIN); i++) begin
        slot_xs[i] <= '0;
        slot_xw[i] <= '0;
        slot_ys[i] <= '0;
        slot_yw[i] <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      for (int i = 0; i < int'(N_WIN); i++) begin
        if (cfg_idx == 2'(i)) begin
          slot_en[i] <= cfg_en;
          slot_xs[i] <= cfg_x_start;
          slot_xw[i] <= cfg_x_win;
          slot_ys[i] <= cfg_y_start;
          slot_yw[i] <= cfg_y_win;
        end
      end
    end
  end

  // Round-robin pick starting after last_idx; last_idx itself is tried last.
  always_comb begin
    found = 1'b0;
    sel   = last_idx_q;
    cand  = '0;
    for (int k = 1; k <= int'(N_WIN); k++) begin
      cand = 2'((int'(last_idx_q) + k) % int'(N_WIN));
      if (!found && slot_en[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Frame markers; EOF is compared against the scheduled window at 12 bits.
  always_comb begin
    x_end = {1'b0, x_start_q} + {1'b0, x_win_q} - 12'd1;
    y_end = {1'b0, y_start_q} + {1'b0, y_win_q} - 12'd1;
    sof   = in_valid && (in_x == 11'd0) && (in_y == 11'd0);
    eof   = in_valid && ({1'b0, in_x} == x_end) && ({1'b0, in_y} == y_end);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle:    if (in_enable && (|slot_en)) state_d = StArm;
      StArm: begin
        if (!in_enable || !found) begin
          state_d = StIdle;
        end else begin
          state_d = StWaitSof;
          load    = 1'b1;
        end
      end
      StWaitSof: begin
        if (!in_enable) state_d = StIdle;
        else if (sof)   state_d = StActive;
      end
      // A new SOF before EOF means a short frame: abandon the window.
      StActive:  if (eof || sof) state_d = StWaitAck;
      StWaitAck: if (in_ack) state_d = in_enable ? StArm : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State and registered outputs; geometry only changes when ARM loads it.
  always_ff @(posedge in_pclk or negedge in_arstn) begin
    if (!in_arstn) begin
      state_q    <= StIdle;
      last_idx_q <= 2'(N_WIN - 1);
      x_start_q  <= '0;
      x_win_q    <= '0;
      y_start_q  <= '0;
      y_win_q    <= '0;
      win_idx_q  <= '0;
      crop_en_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != StIdle);
      crop_en_q <= (state_d == StActive);
      done_q    <= (state_q == StActive) && (state_d == StWaitAck);
      cfg_err_q <= cfg_we && !cfg_ok;
      if (load) begin
        x_start_q  <= slot_xs[sel];
        x_win_q    <= slot_xw[sel];
        y_start_q  <= slot_ys[sel];
        y_win_q    <= slot_yw[sel];
        win_idx_q  <= sel;
        last_idx_q <= sel;
      end
    end
  end

  assign out_x_start = x_start_q;
  assign out_x_win   = x_win_q;
  assign out_y_start = y_start_q;
  assign out_y_win   = y_win_q;
  assign out_win_idx = win_idx_q;
  assign out_crop_en = crop_en_q;
  assign out_done    = done_q;
  assign out_busy    = busy_q;
  assign out_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_tinyml_crop_scheduler.sv
// Self-checking bench for tinyml_crop_scheduler: randomized configs and pixel
// streams checked against a frame-level reference model.
module tb_tinyml_crop_scheduler;

  logic        in_pclk = 1'b0, in_arstn = 1'b0, in_enable = 1'b0;
  logic        cfg_we = 1'b0, cfg_en = 1'b0, in_valid = 1'b0, in_ack = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [10:0] cfg_x_start = '0, cfg_x_win = '0, cfg_y_start = '0, cfg_y_win = '0;
  logic [10:0] in_x = '0, in_y = '0;
  logic [10:0] out_x_start, out_x_win, out_y_start, out_y_win;
  logic [1:0]  out_win_idx;
  logic        out_crop_en, out_done, out_busy, out_cfg_err;

  int checks = 0;
  int failures = 0;

  tinyml_crop_scheduler #(.N_WIN(4)) dut (
    .in_pclk(in_pclk), .in_arstn(in_arstn), .in_enable(in_enable),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_x_start(cfg_x_start), .cfg_x_win(cfg_x_win),
    .cfg_y_start(cfg_y_start), .cfg_y_win(cfg_y_win),
    .in_x(in_x), .in_y(in_y), .in_valid(in_valid), .in_ack(in_ack),
    .out_x_start(out_x_start), .out_x_win(out_x_win),
    .out_y_start(out_y_start), .out_y_win(out_y_win),
    .out_win_idx(out_win_idx), .out_crop_en(out_crop_en), .out_done(out_done),
    .out_busy(out_busy), .out_cfg_err(out_cfg_err)
  );

  always #5 in_pclk = ~in_pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_pclk);
    #1;
  endtask

  // Reference model: slot table, round-robin pointer, currently scheduled window.
  int m_en[4], m_xs[4], m_xw[4], m_ys[4], m_yw[4];
  int m_last;
  int ex_idx, ex_xs, ex_xw, ex_ys, ex_yw;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0; m_xs[i] = 0; m_xw[i] = 0; m_ys[i] = 0; m_yw[i] = 0;
    end
    m_last = 3;
  endfunction

  function automatic void model_arm();
    for (int k = 1; k <= 4; k++) begin
      int idx = (m_last + k) % 4;
      if (m_en[idx] != 0) begin
        ex_idx = idx; ex_xs = m_xs[idx]; ex_xw = m_xw[idx];
        ex_ys = m_ys[idx]; ex_yw = m_yw[idx];
        m_last = idx;
        return;
      end
    end
  endfunction

  task automatic cfg_write(input int idx, input int en, input int xs, input int xw,
                           input int ys, input int yw);
    bit bad;
    bad = (idx >= 4) || (xw == 0) || (yw == 0) || (xs + xw > 2048) || (ys + yw > 2048);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = 1'(en);
    cfg_x_start = 11'(xs); cfg_x_win = 11'(xw); cfg_y_start = 11'(ys); cfg_y_win = 11'(yw);
    tick();
    cfg_we = 1'b0;
    check_eq("cfg_err", 32'(out_cfg_err), 32'(bad));
    if (!bad) begin
      m_en[idx] = en; m_xs[idx] = xs; m_xw[idx] = xw; m_ys[idx] = ys; m_yw[idx] = yw;
    end
  endtask

  task automatic expect_armed(input string nm);
    check_eq({nm, "_idx"}, 32'(out_win_idx), 32'(ex_idx));
    check_eq({nm, "_xs"}, 32'(out_x_start), 32'(ex_xs));
    check_eq({nm, "_xw"}, 32'(out_x_win), 32'(ex_xw));
    check_eq({nm, "_ys"}, 32'(out_y_start), 32'(ex_ys));
    check_eq({nm, "_yw"}, 32'(out_y_win), 32'(ex_yw));
    check_eq({nm, "_busy"}, 32'(out_busy), 32'd1);
    check_eq({nm, "_crop_idle"}, 32'(out_crop_en), 32'd0);
  endtask

  typedef struct packed {logic v; logic [10:0] x; logic [10:0] y;} px_t;
  px_t px_q[$];

  // Valid pixel, sometimes preceded by an invalid bubble with random coordinates.
  function automatic void push_px(int x, int y);
    px_t p;
    if ($urandom_range(0, 5) == 0) begin
      p.v = 1'b0; p.x = 11'($urandom_range(0, 2047)); p.y = 11'($urandom_range(0, 2047));
      px_q.push_back(p);
    end
    p.v = 1'b1; p.x = 11'(x); p.y = 11'(y);
    px_q.push_back(p);
  endfunction

  // Sparse 1920-wide raster: only the columns that matter are sent per line.
  function automatic void build_sparse(int lines, bit close_sof);
    int cols[5] = '{0, 100, 339, 500, 1919};
    px_q.delete();
    for (int y = 0; y < lines; y++)
      for (int j = 0; j < 5; j++) push_px(cols[j], y);
    if (close_sof) push_px(0, 0);
  endfunction

  function automatic void build_dense(int w, int h);
    px_q.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) push_px(x, y);
  endfunction

  // Drive px_q from WAIT_SOF and check crop_en/done timing against the model.
  task automatic run_stream(input int drop_at, input string nm);
    int sof_i = -1, e = -1, crop_first = -1, crop_cnt = 0, done_cnt = 0, done_at = -1;
    int busy_e = 0;
    int xe = ex_xs + ex_xw - 1;
    int ye = ex_ys + ex_yw - 1;
    for (int i = 0; i < px_q.size(); i++) begin
      if (px_q[i].v) begin
        if (sof_i < 0) begin
          if (px_q[i].x == 0 && px_q[i].y == 0) sof_i = i;
        end else if (e < 0 && ((int'(px_q[i].x) == xe && int'(px_q[i].y) == ye) ||
                               (px_q[i].x == 0 && px_q[i].y == 0))) begin
          e = i;
        end
      end
    end
    for (int i = 0; i < px_q.size(); i++) begin
      if (i == drop_at) in_enable = 1'b0;
      in_valid = px_q[i].v; in_x = px_q[i].x; in_y = px_q[i].y;
      tick();
      if (out_crop_en) begin
        if (crop_first < 0) crop_first = i;
        crop_cnt++;
      end
      if (out_done) begin
        done_cnt++;
        done_at = i;
      end
      if (i == e) busy_e = 32'(out_busy);
    end
    in_valid = 1'b0;
    repeat (2) begin
      tick();
      if (out_done) done_cnt++;
      if (out_crop_en) crop_cnt++;
    end
    check_eq({nm, "_crop_rise"}, 32'(crop_first), 32'(sof_i));
    check_eq({nm, "_crop_len"}, 32'(crop_cnt), 32'(e - sof_i));
    check_eq({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({nm, "_done_at"}, 32'(done_at), 32'(e));
    check_eq({nm, "_busy_eof"}, 32'(busy_e), 32'd1);
  endtask

  task automatic ack_frame();
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
  endtask

  function automatic int rnd_small_start();
    return int'($urandom_range(1, 7));
  endfunction

  initial begin
    int idx_seq[5] = '{0, 1, 3, 0, 1};
    int drop_at, stop_at, done_cnt, busy_max;

    model_reset();
    repeat (3) tick();
    check_eq("rst_busy", 32'(out_busy), 32'd0);
    check_eq("rst_crop", 32'(out_crop_en), 32'd0);
    check_eq("rst_done", 32'(out_done), 32'd0);
    check_eq("rst_err", 32'(out_cfg_err), 32'd0);
    check_eq("rst_geom", 32'({out_x_start, out_x_win, out_win_idx}), 32'd0);
    check_eq("rst_geom_y", 32'({out_y_start, out_y_win}), 32'd0);
    @(negedge in_pclk);
    in_arstn = 1'b1;
    tick();

    // Configuration: valid slot 0, then rejected writes must leave it intact.
    cfg_write(0, 1, 100, 240, 0, 540);
    cfg_write(0, 1, 2000, 100, 0, 540);
    cfg_write(0, 1, 5, 0, 5, 5);
    cfg_write(0, 1, 5, 5, 5, 0);
    cfg_write(0, 1, 0, 10, 2000, 49);
    cfg_write(2, 0, 0, 10, 1990, 58);
    repeat (8) cfg_write($urandom_range(1, 3), 0, $urandom_range(0, 2047),
                         $urandom_range(0, 2047), $urandom_range(0, 2047),
                         $urandom_range(0, 2047));
    check_eq("idle_no_enable", 32'(out_busy), 32'd0);

    // Full-size frame on slot 0, enable dropped mid-window.
    in_enable = 1'b1;
    tick();
    model_arm();
    tick();
    expect_armed("f20");
    check_eq("f20_x_start", 32'(out_x_start), 32'd100);
    build_sparse(1080, 1'b0);
    drop_at = 0;
    for (int i = 0; i < px_q.size(); i++)
      if (drop_at == 0 && px_q[i].v && px_q[i].y == 300) drop_at = i;
    run_stream(drop_at, "f20");
    ack_frame();
    check_eq("ack_idle_busy", 32'(out_busy), 32'd0);
    tick();
    check_eq("ack_idle_stay", 32'(out_busy), 32'd0);

    // Short frame: 100 lines against a 540-line window.
    in_enable = 1'b1;
    tick();
    model_arm();
    tick();
    expect_armed("short");
    build_sparse(100, 1'b1);
    run_stream(-1, "short");
    check_eq("short_wait_ack", 32'(out_busy), 32'd1);
    check_eq("short_crop_off", 32'(out_crop_en), 32'd0);
    ack_frame();
    model_arm();
    tick();
    expect_armed("rst");

    // Asynchronous reset at pixel (500,300) of an active window.
    build_sparse(1080, 1'b0);
    stop_at = 0;
    for (int i = 0; i < px_q.size(); i++) begin
      in_valid = px_q[i].v; in_x = px_q[i].x; in_y = px_q[i].y;
      tick();
      if (px_q[i].v && px_q[i].x == 500 && px_q[i].y == 300) begin
        stop_at = i;
        break;
      end
    end
    check_eq("pre_rst_crop", 32'(out_crop_en), 32'd1);
    #2 in_arstn = 1'b0;
    #1;
    check_eq("mid_rst_flags", 32'({out_busy, out_crop_en, out_done, out_cfg_err}), 32'd0);
    check_eq("mid_rst_geom", 32'({out_x_start, out_x_win, out_win_idx}), 32'd0);
    check_eq("mid_rst_geom_y", 32'({out_y_start, out_y_win}), 32'd0);
    model_reset();
    @(negedge in_pclk);
    in_arstn = 1'b1;
    done_cnt = 0;
    busy_max = 0;
    for (int i = stop_at + 1; i < px_q.size(); i++) begin
      in_valid = px_q[i].v; in_x = px_q[i].x; in_y = px_q[i].y;
      tick();
      if (out_done) done_cnt++;
      if (out_busy) busy_max = 1;
    end
    in_valid = 1'b0;
    check_eq("post_rst_done", 32'(done_cnt), 32'd0);
    check_eq("post_rst_busy", 32'(busy_max), 32'd0);

    // Round robin over slots 0,1,3 with random small windows.
    in_enable = 1'b0;
    cfg_write(0, 1, rnd_small_start(), $urandom_range(1, 8), $urandom_range(0, 7),
              $urandom_range(1, 8));
    cfg_write(1, 1, rnd_small_start(), $urandom_range(1, 8), $urandom_range(0, 7),
              $urandom_range(1, 8));
    cfg_write(2, 0, rnd_small_start(), $urandom_range(1, 8), $urandom_range(0, 7),
              $urandom_range(1, 8));
    cfg_write(3, 1, rnd_small_start(), $urandom_range(1, 8), $urandom_range(0, 7),
              $urandom_range(1, 8));
    in_enable = 1'b1;
    tick();
    for (int f = 0; f < 5; f++) begin
      model_arm();
      // Frame 2: write the slot being armed in the ARM cycle itself.
      if (f == 2) cfg_write(ex_idx, 1, rnd_small_start(), $urandom_range(1, 8),
                            $urandom_range(0, 7), $urandom_range(1, 8));
      else tick();
      expect_armed("rr");
      check_eq("rr_seq", 32'(out_win_idx), 32'(idx_seq[f]));
      // Frame 1: rewrite the scheduled slot while waiting for SOF.
      if (f == 1) begin
        cfg_write(ex_idx, 1, rnd_small_start(), $urandom_range(1, 8),
                  $urandom_range(0, 7), $urandom_range(1, 8));
        expect_armed("rr_hold");
      end
      build_dense(16, 16);
      run_stream(-1, "rr");
      ack_frame();
    end
    in_enable = 1'b0;
    repeat (3) tick();
    check_eq("final_idle", 32'(out_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
